// File: rtl/dbnc_pkg.sv
// Shared state encoding for the debounce/edge-detect block.
package dbnc_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } dbnc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; a clear and an increment together give 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? W'(1) : '0;
        end else if (inc && (q != MAX)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/dff_debounce_edge.sv
// Debounces a clk-domain level: a new level is accepted after STABLE_CYCLES identical
// samples, producing one-cycle rise/fall pulses and a saturating count of accepted rises.
module dff_debounce_edge
    import dbnc_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned EVT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             clr_cnt,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy,
    output logic [EVT_W-1:0] edge_count
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    dbnc_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, rise_nxt, fall_nxt, busy_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= STABLE_LO;
            cnt        <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            level_out  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            busy       <= busy_nxt;
        end
    end

    // Qualification FSM: a WAIT state counts matching samples and falls back on any mismatch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;

        case (state)
            STABLE_LO: begin
                cnt_nxt = '0;
                if (d_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = STABLE_HI;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT_HI;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!d_in) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                cnt_nxt = '0;
                if (!d_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = STABLE_LO;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT_LO;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT_LO: begin
                if (d_in) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase

        busy_nxt = (state_nxt == WAIT_HI) || (state_nxt == WAIT_LO);
    end

    sat_counter #(.W(EVT_W)) u_edge_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (rise_nxt),
        .q     (edge_count)
    );

endmodule
